// File: rtl/counter_0_30.sv
// BCD up-counter from a loadable preset to LIMIT_DOZENS:LIMIT_UNITS, with start/pause/load control.
// Build option COUNTER_0_30_AUTO_RESTART_EN: wrap to 00 at the limit instead of stopping.
module counter_0_30 #(
   parameter int unsigned LIMIT_DOZENS = 3,
   parameter int unsigned LIMIT_UNITS  = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
   input  logic       start,
   input  logic       pause,
   input  logic       load,
   input  logic [5:0] preset,
   output logic [1:0] dozens,
   output logic [3:0] units,
   output logic       running,
   output logic       time_up,
   output logic       load_err
);

   localparam logic [1:0] LIM_D = LIMIT_DOZENS[1:0];
   localparam logic [3:0] LIM_U = LIMIT_UNITS[3:0];
   localparam logic [5:0] LIMIT = {LIM_D, LIM_U};

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
   state_t state;

   logic [1:0] inc_dozens;
   logic [3:0] inc_units;
   logic       inc_hit;
   logic       preset_ok;
   logic       preset_lim;

   // With valid units digits, packed BCD orders the same as plain binary.
   always_comb begin
      inc_dozens = dozens;
      inc_units  = units;
      if (units != 4'd9) begin
         inc_units = units + 4'd1;
      end else if (dozens != 2'd3) begin
         inc_units  = '0;
         inc_dozens = dozens + 2'd1;
      end
      inc_hit    = ({inc_dozens, inc_units} == LIMIT);
      preset_ok  = (preset[3:0] <= 4'd9) && (preset <= LIMIT);
      preset_lim = (preset == LIMIT);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         dozens   <= '0;
         units    <= '0;
         running  <= 1'b0;
         time_up  <= 1'b0;
         load_err <= 1'b0;
      end else begin
         load_err <= 1'b0;
         time_up  <= ({dozens, units} == LIMIT);
         if (load) begin
            if (preset_ok) begin
               dozens  <= preset[5:4];
               units   <= preset[3:0];
               state   <= preset_lim ? DONE : IDLE;
               running <= 1'b0;
               time_up <= preset_lim;
            end else begin
               load_err <= 1'b1;
            end
         end else if (pause) begin
            if (state == RUN) begin
               state   <= PAUSED;
               running <= 1'b0;
            end
         end else if (start && state != RUN) begin
            if (state == DONE) begin
               dozens  <= '0;
               units   <= '0;
               time_up <= (LIMIT == 6'd0);
            end
            state   <= RUN;
            running <= 1'b1;
         end else if (tick && state == RUN) begin
            if (inc_hit) begin
`ifdef COUNTER_0_30_AUTO_RESTART_EN
               dozens  <= '0;
               units   <= '0;
               time_up <= 1'b1;
`else
               dozens  <= inc_dozens;
               units   <= inc_units;
               state   <= DONE;
               running <= 1'b0;
               time_up <= 1'b1;
`endif
            end else begin
               dozens  <= inc_dozens;
               units   <= inc_units;
               time_up <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/counter_0_30.md
Name: counter_0_30

Overview:
- BCD up-counter, the counting-up counterpart of the 30..0 countdown counter.
- Counts elapsed time from a loadable start value up to a BCD limit (default 30), one step per qualified tick.
- Small control FSM with start, pause and load; asserts time_up when the limit is reached.
- Drives the same dozens/units display path as the countdown counter.

Parameters:
- LIMIT_DOZENS, 3, dozens digit of the terminal value (0..3).
- LIMIT_UNITS, 0, units digit of the terminal value (0..9).

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  count enable; one count per cycle in which it is high.
- start  input  1  single-cycle pulse; begins or resumes counting.
- pause  input  1  single-cycle pulse; suspends counting.
- load  input  1  single-cycle pulse; loads preset.
- preset  input  6  start value; [5:4] dozens, [3:0] units, BCD.
- dozens  output  2  current dozens digit.
- units  output  4  current units digit.
- running  output  1  high in RUN state.
- time_up  output  1  high while the value equals the limit.
- load_err  output  1  one-cycle pulse on a rejected load.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - dozens=0, units=0, state=IDLE.
  - running=0, time_up=0 (valid only if the limit is not 00), load_err=0.
- States:
  - IDLE: value held. start -> RUN.
  - RUN: counting. pause -> PAUSED. Reaching the limit -> DONE.
  - PAUSED: value held. start -> RUN.
  - DONE: value held at the limit. start -> RUN with the value cleared to 00. load is allowed.
- Priority within a cycle: reset > load > pause > start > tick.
- load, in any state:
  - Accepted only if preset[3:0] <= 9 and the BCD value <= limit.
  - Accepted: the value takes preset on the next edge. State -> IDLE, or -> DONE if the preset equals the limit.
  - Rejected: value and state unchanged; load_err high for exactly the following cycle.
- Counting, only in RUN with tick=1:
  - units != 9: units+1.
  - units == 9: units=0, dozens+1.
  - dozens never exceeds 3.
  - Arithmetic is strictly BCD; the units digit never holds A..F.
- Terminal condition:
  - The increment that makes the value equal to the limit also moves the FSM to DONE on the same edge.
  - running falls and time_up rises together, one cycle after the tick that produced the limit value.
- time_up is registered: high whenever the value equals the limit, including after a load of the limit value.
- Edge cases:
  - tick in IDLE, PAUSED or DONE: ignored.
  - start in RUN: no effect.
  - pause outside RUN: no effect.
  - start and pause in the same cycle: pause wins, so RUN -> PAUSED and IDLE/PAUSED stay put.
  - tick in the same cycle as an accepted load: the tick is discarded.
  - Reset mid-count: value returns to 00 on that edge regardless of other inputs.
- Latency: outputs change on the edge after the controlling input; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: COUNTER_0_30_AUTO_RESTART_EN.
- Defined:
  - In RUN, the tick that would reach the limit instead wraps the value to 00 and stays in RUN.
  - time_up becomes a one-cycle pulse on the wrap edge.
  - The DONE state is unreachable except via load of the limit value, which then behaves as in the base build.
- Not defined: saturating behaviour as described above.

Test Plan:
- Reset, start, 30 ticks (default limit) -> value steps 00,01..09,10..29,30.
  - running=1 until the 30th tick; on the next cycle running=0 and time_up=1.
  - Further ticks leave the value at 30.
- Load preset 6'h19 in IDLE, start, 2 ticks -> 19 -> 20 -> 21, confirming the units carry into dozens.
- Load units=4'hA, then load value 31 -> each is rejected: one-cycle load_err pulse, value unchanged, state unchanged.
- RUN at 12, pause, 5 ticks, start, 1 tick -> value holds 12 while paused, then reads 13.
- Reset asserted with tick and start at value 25 -> next cycle value 00, state IDLE, running=0, time_up=0.
- With COUNTER_0_30_AUTO_RESTART_EN, LIMIT 1/5, start from 13, 3 ticks -> 14, 00, 01.
  - time_up high only in the cycle after the wrap; running stays 1 throughout.
